// File: rtl/subleq_sequencer.sv
// Purpose: multi-cycle SUBLEQ controller: fetch A,B,C at pc..pc+2, read mem[A], mem[B], write mem[B]-mem[A], branch to C on result <= 0.
// Latency: 6 cycles per instruction with zero wait states (FA,FB,FC,RA,RB,WB), back to back under run with no bubble.
// Backpressure: every memory state holds while mem_rdy=0; address, write data and strobes stay frozen until the ready cycle.
//
// Ports:
//   clk, res                 rising-edge clock, asynchronous active-low reset
//   run, step                level run / one-instruction pulse (sampled in IDLE)
//   pc_load, pc_val          load PC in IDLE or HALT; clears the halt condition
//   mem_adr, mem_wdat        RAM address / write data
//   mem_re, mem_we           RAM read / write request (exactly one high while busy)
//   mem_rdat, mem_rdy        RAM read data / access-complete
//   pc, busy, halted, leq    architectural status
//   instr_cnt                completed instructions, saturating

module subleq_sequencer #(
    parameter int              AW       = 8,
    parameter int              DW       = 8,
    parameter logic [AW-1:0]   RESET_PC = '0,
    parameter logic [AW-1:0]   HALT_ADR = '1
) (
    input  logic              clk,
    input  logic              res,
    input  logic              run,
    input  logic              step,
    input  logic              pc_load,
    input  logic [AW-1:0]     pc_val,
    output logic [AW-1:0]     mem_adr,
    output logic [DW-1:0]     mem_wdat,
    output logic              mem_re,
    output logic              mem_we,
    input  logic [DW-1:0]     mem_rdat,
    input  logic              mem_rdy,
    output logic [AW-1:0]     pc,
    output logic              busy,
    output logic              halted,
    output logic              leq,
    output logic [15:0]       instr_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FA,
        S_FB,
        S_FC,
        S_RA,
        S_RB,
        S_WB,
        S_HALT
    } state_t;

    state_t state, state_nxt;

    logic [AW-1:0] a_adr, b_adr, c_adr;
    logic [DW-1:0] op_a, op_b;
    logic [DW-1:0] result;
    logic          leq_new;
    logic          branch_halt;

    // The subtraction result is a pure function of the held operands, so it
    // is stable for the whole WB state regardless of how long RAM stalls.
    assign result      = op_b - op_a;
    assign leq_new     = (result == '0) || result[DW-1];
    assign branch_halt = leq_new && (c_adr == HALT_ADR);

    assign busy   = (state != S_IDLE) && (state != S_HALT);
    assign halted = (state == S_HALT);

    // State register
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and memory-side outputs. Outputs are decoded from the state
    // and held registers only, which keeps them glitch-free and frozen across
    // wait states and drops the strobes the instant reset asserts.
    always_comb begin
        state_nxt = state;
        mem_adr   = '0;
        mem_wdat  = '0;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        case (state)
            S_IDLE: begin
                // A load in the same cycle as run/step only loads.
                if (!pc_load && (run || step)) begin
                    state_nxt = S_FA;
                end
            end
            S_FA: begin
                mem_re  = 1'b1;
                mem_adr = pc;
                if (mem_rdy) state_nxt = S_FB;
            end
            S_FB: begin
                mem_re  = 1'b1;
                mem_adr = pc + AW'(1);
                if (mem_rdy) state_nxt = S_FC;
            end
            S_FC: begin
                mem_re  = 1'b1;
                mem_adr = pc + AW'(2);
                if (mem_rdy) state_nxt = S_RA;
            end
            S_RA: begin
                mem_re  = 1'b1;
                mem_adr = a_adr;
                if (mem_rdy) state_nxt = S_RB;
            end
            S_RB: begin
                mem_re  = 1'b1;
                mem_adr = b_adr;
                if (mem_rdy) state_nxt = S_WB;
            end
            S_WB: begin
                mem_we   = 1'b1;
                mem_adr  = b_adr;
                mem_wdat = result;
                if (mem_rdy) begin
                    if (branch_halt) begin
                        state_nxt = S_HALT;
                    end else if (run) begin
                        state_nxt = S_FA;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            S_HALT: begin
                if (pc_load) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath registers. pc is left untouched during fetch so the three
    // fetch addresses are derived from one value; it only moves at WB.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            pc        <= RESET_PC;
            a_adr     <= '0;
            b_adr     <= '0;
            c_adr     <= '0;
            op_a      <= '0;
            op_b      <= '0;
            leq       <= 1'b0;
            instr_cnt <= '0;
        end else begin
            case (state)
                S_IDLE, S_HALT: begin
                    if (pc_load) pc <= pc_val;
                end
                S_FA: if (mem_rdy) a_adr <= mem_rdat[AW-1:0];
                S_FB: if (mem_rdy) b_adr <= mem_rdat[AW-1:0];
                S_FC: if (mem_rdy) c_adr <= mem_rdat[AW-1:0];
                S_RA: if (mem_rdy) op_a  <= mem_rdat;
                S_RB: if (mem_rdy) op_b  <= mem_rdat;
                S_WB: begin
                    if (mem_rdy) begin
                        leq <= leq_new;
                        pc  <= leq_new ? c_adr : pc + AW'(3);
                        if (instr_cnt != 16'hFFFF) begin
                            instr_cnt <= instr_cnt + 16'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_subleq_sequencer.sv
// Purpose: scoreboard bench for subleq_sequencer with a behavioural SUBLEQ interpreter and a wait-state RAM.
// Latency: expectations are queued at issue time and retired when the RAM sees each write-back complete.
// Backpressure: the RAM model inserts wait_n stall cycles per access, or holds writes indefinitely when stall_we is set.
module tb_subleq_sequencer;

    logic       clk = 1'b0;
    logic       res = 1'b0;
    logic       run = 1'b0;
    logic       step = 1'b0;
    logic       pc_load = 1'b0;
    logic [7:0] pc_val = 8'h00;
    logic [7:0] mem_adr;
    logic [7:0] mem_wdat;
    logic       mem_re;
    logic       mem_we;
    logic [7:0] mem_rdat = 8'h00;
    logic       mem_rdy = 1'b0;
    logic [7:0] pc;
    logic       busy;
    logic       halted;
    logic       leq;
    logic [15:0] instr_cnt;

    subleq_sequencer dut (
        .clk       (clk),
        .res       (res),
        .run       (run),
        .step      (step),
        .pc_load   (pc_load),
        .pc_val    (pc_val),
        .mem_adr   (mem_adr),
        .mem_wdat  (mem_wdat),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .mem_rdat  (mem_rdat),
        .mem_rdy   (mem_rdy),
        .pc        (pc),
        .busy      (busy),
        .halted    (halted),
        .leq       (leq),
        .instr_cnt (instr_cnt)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: actual %0h required %0h", name, act, expv);
        end
    endtask

    // ---------------- behavioural reference ----------------
    logic [7:0]  ram     [256];
    logic [7:0]  ref_mem [256];
    logic [7:0]  ref_pc     = 8'h00;
    logic        ref_leq    = 1'b0;
    logic        ref_halted = 1'b0;
    logic [15:0] ref_cnt    = 16'h0000;
    int          wait_n     = 0;
    bit          stall_we   = 1'b0;

    typedef struct {
        logic [7:0]  f0, f1, f2, ra, rb, wadr, wdat, pc_after;
        logic        leq_after, halt_after;
        logic [15:0] cnt_after;
        int          cycles;
    } exp_t;
    exp_t exp_q[$];

    task automatic poke(input logic [7:0] adr, input logic [7:0] val);
        ram[adr]     = val;
        ref_mem[adr] = val;
    endtask

    // Execute one SUBLEQ instruction on the reference memory and queue what
    // the DUT must show for it.
    task automatic model_step();
        exp_t e;
        logic [7:0] a, b, c, r;
        e.f0 = ref_pc;
        e.f1 = ref_pc + 8'd1;
        e.f2 = ref_pc + 8'd2;
        a = ref_mem[e.f0];
        b = ref_mem[e.f1];
        c = ref_mem[e.f2];
        r = ref_mem[b] - ref_mem[a];
        ref_mem[b] = r;
        ref_leq = ($signed(r) <= 0);
        ref_pc  = ref_leq ? c : ref_pc + 8'd3;
        if (ref_cnt != 16'hFFFF) ref_cnt = ref_cnt + 16'd1;
        if (ref_leq && c == 8'hFF) ref_halted = 1'b1;
        e.ra = a; e.rb = b; e.wadr = b; e.wdat = r;
        e.pc_after = ref_pc; e.leq_after = ref_leq; e.halt_after = ref_halted;
        e.cnt_after = ref_cnt; e.cycles = 6 * (wait_n + 1);
        exp_q.push_back(e);
    endtask

    // ---------------- RAM model + monitor ----------------
    logic [7:0]  rd_list[$];
    int          bcnt = 0;
    int          wcnt = 0;
    int          n_ret = 0;
    bit          ack_pend = 1'b0;
    bit          ack_we = 1'b0;
    logic [7:0]  ack_adr, ack_dat;
    logic [17:0] snap;

    always @(negedge clk) begin
        if (!res) begin
            ack_pend = 1'b0;
            wcnt     = 0;
            bcnt     = 0;
            rd_list.delete();
            mem_rdy  = 1'b0;
        end else begin
            // Retire the access acknowledged at the previous rising edge.
            if (ack_pend) begin
                ack_pend = 1'b0;
                if (!ack_we) begin
                    rd_list.push_back(ack_adr);
                end else begin
                    exp_t e;
                    n_ret++;
                    ram[ack_adr] = ack_dat;
                    check("write_expected", 32'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("read_count", rd_list.size(), 5);
                        if (rd_list.size() == 5) begin
                            check("fetch_a_adr", rd_list[0], e.f0);
                            check("fetch_b_adr", rd_list[1], e.f1);
                            check("fetch_c_adr", rd_list[2], e.f2);
                            check("read_a_adr",  rd_list[3], e.ra);
                            check("read_b_adr",  rd_list[4], e.rb);
                        end
                        check("wr_adr",   ack_adr,   e.wadr);
                        check("wr_dat",   ack_dat,   e.wdat);
                        check("pc_after", pc,        e.pc_after);
                        check("leq",      leq,       e.leq_after);
                        check("halted",   halted,    e.halt_after);
                        check("instr_cnt", instr_cnt, e.cnt_after);
                        check("busy_cycles", bcnt,   e.cycles);
                    end
                    rd_list.delete();
                    bcnt = 0;
                end
            end
            if (busy) bcnt++;
            check("one_strobe", int'(mem_re) + int'(mem_we), busy ? 1 : 0);
            if (mem_re || mem_we) begin
                if (wcnt == 0) snap = {mem_adr, mem_wdat, mem_re, mem_we};
                else check("access_stable", {mem_adr, mem_wdat, mem_re, mem_we}, snap);
                if (mem_we && stall_we) begin
                    mem_rdy = 1'b0;
                    wcnt++;
                end else if (wcnt >= wait_n) begin
                    mem_rdy  = 1'b1;
                    mem_rdat = mem_re ? ram[mem_adr] : 8'($urandom);
                    ack_pend = 1'b1;
                    ack_we   = mem_we;
                    ack_adr  = mem_adr;
                    ack_dat  = mem_wdat;
                    wcnt     = 0;
                end else begin
                    mem_rdy  = 1'b0;
                    mem_rdat = 8'($urandom);
                    wcnt++;
                end
            end else begin
                mem_rdy = 1'b0;
                wcnt    = 0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_done(input int target);
        int k;
        for (k = 0; k < 2000; k++) begin
            @(negedge clk); #1;
            if (n_ret >= target && !busy) break;
        end
        check("done_in_time", 32'(k < 2000), 1);
        repeat (3) @(negedge clk);
        #1;
        check("stays_idle",  busy,          0);
        check("final_pc",    pc,            ref_pc);
        check("final_cnt",   instr_cnt,     ref_cnt);
        check("final_halt",  halted,        ref_halted);
        check("queue_empty", exp_q.size(),  0);
    endtask

    task automatic do_load(input logic [7:0] v);
        @(negedge clk); #1;
        pc_load = 1'b1;
        pc_val  = v;
        @(negedge clk); #1;
        pc_load = 1'b0;
        ref_pc = v;
        ref_halted = 1'b0;
        check("load_pc",     pc,     v);
        check("load_halted", halted, 0);
        check("load_busy",   busy,   0);
    endtask

    task automatic issue_step(input bit extra);
        int base;
        base = n_ret;
        model_step();
        @(negedge clk); #1; step = 1'b1;
        @(negedge clk); #1; step = 1'b0;
        if (extra) begin
            repeat (2) @(negedge clk);
            #1; step = 1'b1;
            @(negedge clk); #1; step = 1'b0;
        end
        wait_done(base + 1);
    endtask

    task automatic issue_run(input int n);
        int base, cnt, k;
        base = n_ret;
        cnt  = 0;
        while (cnt < n && !ref_halted) begin
            model_step();
            cnt++;
        end
        if (cnt == 0) return;
        @(negedge clk); #1; run = 1'b1;
        for (k = 0; k < 2000; k++) begin
            @(negedge clk); #1;
            if (n_ret >= base + cnt - 1) break;
        end
        run = 1'b0;
        wait_done(base + cnt);
    endtask

    task automatic reset_model();
        ref_pc = 8'h00; ref_leq = 1'b0; ref_cnt = 16'h0000; ref_halted = 1'b0;
        exp_q.delete();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        for (int i = 0; i < 256; i++) begin
            ram[i] = 8'h00;
            ref_mem[i] = 8'h00;
        end
        repeat (2) @(negedge clk);
        #1;
        check("rst_pc",       pc,        0);
        check("rst_busy",     busy,      0);
        check("rst_halted",   halted,    0);
        check("rst_leq",      leq,       0);
        check("rst_re_we",    {mem_re, mem_we}, 0);
        check("rst_adr",      mem_adr,   0);
        check("rst_wdat",     mem_wdat,  0);
        check("rst_cnt",      instr_cnt, 0);
        res = 1'b1;

        // pc_load wins over step in the same cycle
        @(negedge clk); #1;
        pc_load = 1'b1; pc_val = 8'h20; step = 1'b1;
        @(negedge clk); #1;
        pc_load = 1'b0; step = 1'b0;
        check("prio_busy", busy, 0);
        check("prio_pc",   pc,   8'h20);
        @(negedge clk); #1;
        check("prio_still_idle", busy, 0);
        do_load(8'h00);

        // step, not taken; extra step pulse mid-instruction is ignored
        poke(0, 3); poke(1, 4); poke(2, 6); poke(3, 5); poke(4, 7);
        issue_step(1'b1);
        check("t1_mem4", ram[4], 8'h02);
        check("t1_leq",  leq,    0);
        check("t1_pc",   pc,     8'h03);
        check("t1_cnt",  instr_cnt, 1);

        // taken on zero, then on negative
        do_load(8'h00);
        poke(3, 7); poke(4, 7);
        issue_step(1'b0);
        check("t2_mem4_zero", ram[4], 8'h00);
        check("t2_pc_zero",   pc,     8'h06);
        check("t2_leq_zero",  leq,    1);
        do_load(8'h00);
        poke(3, 7); poke(4, 5);
        issue_step(1'b0);
        check("t2_mem4_neg", ram[4], 8'hFE);
        check("t2_leq_neg",  leq,    1);
        check("t2_pc_neg",   pc,     8'h06);

        // PC wrap across address FF
        do_load(8'hFE);
        poke(8'hFE, 8'h10); poke(8'hFF, 8'h11); poke(8'h00, 8'h20);
        poke(8'h10, 1); poke(8'h11, 5);
        issue_step(1'b0);
        check("wrap_pc", pc, 8'h01);

        // two wait states per access: 18 cycles per instruction under run
        wait_n = 2;
        do_load(8'h40);
        for (int i = 0; i < 3; i++) begin
            poke(8'h40 + 8'(3 * i), 8'h50);
            poke(8'h41 + 8'(3 * i), 8'h51);
            poke(8'h42 + 8'(3 * i), 8'h40);
        end
        poke(8'h50, 1); poke(8'h51, 3);
        issue_run(4);
        check("ws_mem51", ram[8'h51], 8'hFF);
        wait_n = 0;

        // halt under run; run is ignored until pc_load
        do_load(8'h00);
        poke(0, 3); poke(1, 4); poke(2, 8'hFF); poke(3, 9); poke(4, 9);
        issue_run(3);
        @(negedge clk); #1; run = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        check("halt_flag", halted, 1);
        check("halt_busy", busy,   0);
        check("halt_pc",   pc,     8'hFF);
        check("halt_cnt",  instr_cnt, ref_cnt);
        run = 1'b0;
        do_load(8'h00);

        // reset while WB is stalled: write must not land
        poke(0, 3); poke(1, 4); poke(2, 6); poke(3, 5); poke(4, 7);
        stall_we = 1'b1;
        @(negedge clk); #1; step = 1'b1;
        @(negedge clk); #1; step = 1'b0;
        begin
            int k;
            for (k = 0; k < 100; k++) begin
                @(negedge clk); #1;
                if (mem_we) break;
            end
            check("reached_wb", mem_we, 1);
        end
        repeat (2) @(negedge clk);
        #2; res = 1'b0;
        #1;
        check("rwb_we",   mem_we,    0);
        check("rwb_re",   mem_re,    0);
        check("rwb_adr",  mem_adr,   0);
        check("rwb_pc",   pc,        0);
        check("rwb_busy", busy,      0);
        check("rwb_cnt",  instr_cnt, 0);
        @(negedge clk); #1;
        res = 1'b1;
        stall_we = 1'b0;
        reset_model();
        repeat (3) @(negedge clk);
        #1;
        check("rwb_mem4", ram[4], ref_mem[4]);
        check("rwb_idle", busy,   0);

        // randomized programs over the whole memory
        for (int i = 0; i < 256; i++) poke(8'(i), 8'($urandom));
        for (int it = 0; it < 25; it++) begin
            wait_n = $urandom_range(0, 2);
            if (ref_halted || ($urandom_range(0, 3) == 0)) do_load(8'($urandom));
            if ($urandom_range(0, 1) == 0) issue_step(1'($urandom));
            else issue_run($urandom_range(1, 6));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/subleq_sequencer.md
Name: subleq_sequencer

Overview:
Multi-cycle controller that sequences the SUBLEQ datapath: PC, operand-address registers, the 8-bit subtractor and the shared RAM. For each instruction it fetches three address bytes, reads both operands, writes back mem[B]-mem[A], and branches on a result <= 0. It exposes run/step/load control for the bench and a debug host, and handshakes with RAM through a ready signal so slow memories can insert wait states.

Parameters:
AW, 8, address width (RAM depth 2^AW; PC and all address arithmetic modulo 2^AW)
DW, 8, data width; subtraction is two's-complement DW-bit
RESET_PC, 0, PC value on reset
HALT_ADR, 8'hFF, a taken branch to this address halts the machine

Ports:
clk  in  1  clock, rising edge
res  in  1  asynchronous reset, active low
run  in  1  level; while high, execute instructions back to back
step  in  1  single-cycle pulse; execute exactly one instruction from IDLE
pc_load  in  1  in IDLE or HALT: PC <= pc_val, clears halted
pc_val  in  AW  load value for pc_load
mem_adr  out  AW  RAM address
mem_wdat  out  DW  RAM write data
mem_re  out  1  read request
mem_we  out  1  write request
mem_rdat  in  DW  RAM read data, valid when mem_rdy=1 during a read
mem_rdy  in  1  access complete this cycle
pc  out  AW  current program counter
busy  out  1  instruction in progress
halted  out  1  sticky halt flag
leq  out  1  last result <= 0 (signed)
instr_cnt  out  16  completed instructions, saturates at 16'hFFFF

Behaviour:
- Reset (res=0, asynchronous): state IDLE; pc=RESET_PC; busy, halted, leq, mem_re, mem_we = 0; mem_adr, mem_wdat = 0; instr_cnt=0; internal A/B/C/opA/opB regs = 0. Reset mid-instruction abandons it; no write completes after reset asserts.
- States: IDLE, FA, FB, FC, RA, RB, WB, HALT.
- IDLE: leave to FA when run=1 or step=1. pc_load takes priority over run/step in the same cycle (load only; start on the next cycle).
- FA/FB/FC: mem_re=1, mem_adr = pc, pc+1, pc+2 (mod 2^AW); on mem_rdy capture mem_rdat into A/B/C and advance.
- RA: read mem[A] into opA. RB: read mem[B] into opB.
- WB: mem_we=1, mem_adr=B, mem_wdat=opB-opA (mod 2^DW). On mem_rdy: leq <= (result==0 or result[DW-1]==1); pc <= leq_new ? C : pc+3 (mod 2^AW); instr_cnt++ (saturating). Next state: HALT if branch taken and C==HALT_ADR; else FA if run=1; else IDLE.
- Every memory state holds while mem_rdy=0; mem_adr, mem_wdat, mem_re, mem_we must stay stable until the ready cycle. Exactly one of mem_re/mem_we is high in FA..WB, both low in IDLE/HALT.
- Zero wait states: 6 cycles per instruction (FA..WB), continuous under run with no bubble.
- busy=1 in FA..WB, 0 in IDLE/HALT.
- step while run=1 has no extra effect. step during execution is ignored. Deasserting run mid-instruction completes the instruction, then IDLE.
- HALT: halted=1, pc=HALT_ADR; run/step ignored; only pc_load (to IDLE, halted=0) or reset leaves.
- Self-modifying code is legal: fetches always re-read RAM.

Test Plan:
- Reset mid-WB: mem_rdy=0 in WB, assert res=0 -> mem_we falls immediately, pc=0, state IDLE, RAM unchanged.
- Step, not taken: mem[0..2]={3,4,6}, mem[3]=5, mem[4]=7, mem_rdy=1, one step pulse -> busy for exactly 6 cycles, mem[4]=2, leq=0, pc=3, instr_cnt=1, back to IDLE.
- Taken on zero and negative: mem[3]=7, mem[4]=7 -> mem[4]=0, pc=6, leq=1; then mem[3]=7, mem[4]=5 -> mem[4]=8'hFE, leq=1, branch taken.
- Halt: instruction {3,4,8'hFF} with result 0 under run=1 -> halted=1, busy=0, pc=FF, run ignored; pc_load with pc_val=0 -> halted=0, IDLE.
- Wait states: mem_rdy low 2 cycles before each ack -> 18 cycles per instruction, address/data/strobes stable throughout each access.
- PC wrap: pc_load FE, mem[FE,FF,00]={10,11,20}, positive result -> fetch addresses FE,FF,00, pc=01.
